ex_mem_stage_reg: RTL and testbench

//  Parametrised EX->MEM pipeline register for the OpenMIPS core, successor to the fixed-width EX/MEM latch.

---
 rtl/ex_mem_stage_reg_pkg.sv | 27 ++
 rtl/ex_mem_stage_reg_sat.sv | 27 ++
 rtl/ex_mem_stage_reg.sv | 141 ++++++++++++++
 tb/tb_ex_mem_stage_reg.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_stage_reg_pkg.sv
// Shared constants and helpers for the EX->MEM stage register.
// Decides how the pipeline payload reacts to reset, flush and the stall vector each cycle.
package ex_mem_stage_reg_pkg;

  localparam logic STOP          = 1'b1;
  localparam logic NO_STOP       = 1'b0;
  localparam logic RST_ENABLE    = 1'b1;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    ACT_CLEAR,
    ACT_BUBBLE,
    ACT_ADVANCE,
    ACT_HOLD
  } pipe_act_e;

  // Flush outranks every stall combination; a stall with a running downstream stage inserts a bubble.
  function automatic pipe_act_e pipe_action(input logic rst, input logic flush,
                                            input logic s, input logic n);
    if (rst == RST_ENABLE || flush) return ACT_CLEAR;
    if (s == NO_STOP)               return ACT_ADVANCE;
    if (n == NO_STOP)               return ACT_BUBBLE;
    return ACT_HOLD;
  endfunction

endpackage

// File: rtl/ex_mem_stage_reg_sat.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = '0;
    else if (inc_i && cnt_q != '1) cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX->MEM pipeline register with stall/bubble/flush handling, multi-cycle context
// feedback to EX and a saturating stall-cycle counter.
module ex_mem_stage_reg
  import ex_mem_stage_reg_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned STALL_W = 6,
  parameter int          STAGE   = 3,
  parameter int unsigned PERF_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic                perf_clr,
  input  logic                ex_valid,
  input  logic [ADDR_W-1:0]   ex_wd,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic                ex_whilo,
  input  logic [2*DATA_W-1:0] ctx_i,
  input  logic [CNT_W-1:0]    ctx_cnt_i,
  output logic                mem_valid,
  output logic [ADDR_W-1:0]   mem_wd,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic                mem_whilo,
  output logic [2*DATA_W-1:0] ctx_o,
  output logic [CNT_W-1:0]    ctx_cnt_o,
  output logic [PERF_W-1:0]   stall_cycles
);

  if (STAGE < 0 || STAGE > int'(STALL_W) - 2) begin : g_bad_stage
    $error("ex_mem_stage_reg: STAGE out of range 0..STALL_W-2");
  end

  logic      s, n;
  pipe_act_e act;

  assign s   = stall[STAGE];
  assign n   = stall[STAGE+1];
  assign act = pipe_action(rst, flush, s, n);

  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   wd_q, wd_d;
  logic                wreg_q, wreg_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                whilo_q, whilo_d;
  logic [2*DATA_W-1:0] ctx_q;
  logic [CNT_W-1:0]    ctx_cnt_q;

  always_comb begin
    valid_d = valid_q;
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    whilo_d = whilo_q;
    case (act)
      ACT_CLEAR, ACT_BUBBLE: begin
        valid_d = 1'b0;
        wd_d    = '0;
        wreg_d  = WRITE_DISABLE;
        wdata_d = '0;
        hi_d    = '0;
        lo_d    = '0;
        whilo_d = WRITE_DISABLE;
      end
      ACT_ADVANCE: begin
        // Write enables are qualified by valid so an invalid slot can never commit.
        valid_d = ex_valid;
        wd_d    = ex_wd;
        wreg_d  = ex_wreg & ex_valid;
        wdata_d = ex_wdata;
        hi_d    = ex_hi;
        lo_d    = ex_lo;
        whilo_d = ex_whilo & ex_valid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      wd_q    <= '0;
      wreg_q  <= WRITE_DISABLE;
      wdata_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      whilo_q <= WRITE_DISABLE;
    end else begin
      valid_q <= valid_d;
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      whilo_q <= whilo_d;
    end
  end

  // Context follows EX while stalled and is cleared on advance so the next op starts clean.
  always_ff @(posedge clk) begin
    if (rst || flush || s == NO_STOP) begin
      ctx_q     <= '0;
      ctx_cnt_q <= '0;
    end else begin
      ctx_q     <= ctx_i;
      ctx_cnt_q <= ctx_cnt_i;
    end
  end

  sat_counter #(.WIDTH(PERF_W)) u_perf (
    .clk   (clk),
    .rst   (rst),
    .inc_i (s),
    .clr_i (perf_clr),
    .cnt_o (stall_cycles)
  );

  assign mem_valid = valid_q;
  assign mem_wd    = wd_q;
  assign mem_wreg  = wreg_q;
  assign mem_wdata = wdata_q;
  assign mem_hi    = hi_q;
  assign mem_lo    = lo_q;
  assign mem_whilo = whilo_q;
  assign ctx_o     = ctx_q;
  assign ctx_cnt_o = ctx_cnt_q;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_ex_mem_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic        perf_clr = 1'b0;
  logic        ex_valid = 1'b0;
  logic [4:0]  ex_wd = '0;
  logic        ex_wreg = 1'b0;
  logic [31:0] ex_wdata = '0;
  logic [31:0] ex_hi = '0;
  logic [31:0] ex_lo = '0;
  logic        ex_whilo = 1'b0;
  logic [63:0] ctx_i = '0;
  logic [1:0]  ctx_cnt_i = '0;

  logic        mem_valid, mem_wreg, mem_whilo;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic [63:0] ctx_o;
  logic [1:0]  ctx_cnt_o;
  logic [15:0] stall_cycles;

  logic        m4_valid, m4_wreg, m4_whilo;
  logic [4:0]  m4_wd;
  logic [31:0] m4_wdata, m4_hi, m4_lo;
  logic [63:0] m4_ctx;
  logic [1:0]  m4_ctx_cnt;
  logic [3:0]  stall_cycles4;

  int vectors = 0;
  int miscompares = 0;

  ex_mem_stage_reg u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .perf_clr(perf_clr),
    .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo), .ctx_i(ctx_i), .ctx_cnt_i(ctx_cnt_i),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo), .ctx_o(ctx_o),
    .ctx_cnt_o(ctx_cnt_o), .stall_cycles(stall_cycles)
  );

  ex_mem_stage_reg #(.PERF_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .perf_clr(perf_clr),
    .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo), .ctx_i(ctx_i), .ctx_cnt_i(ctx_cnt_i),
    .mem_valid(m4_valid), .mem_wd(m4_wd), .mem_wreg(m4_wreg), .mem_wdata(m4_wdata),
    .mem_hi(m4_hi), .mem_lo(m4_lo), .mem_whilo(m4_whilo), .ctx_o(m4_ctx),
    .ctx_cnt_o(m4_ctx_cnt), .stall_cycles(stall_cycles4)
  );

  always #5 clk = ~clk;

  // Behavioural reference: what the stage should present after the next edge.
  typedef struct {
    bit          valid, wreg, whilo;
    bit [4:0]    wd;
    bit [31:0]   wdata, hi, lo;
    bit [63:0]   ctx;
    bit [1:0]    ctx_cnt;
    int          perf16, perf4;
  } model_t;

  model_t m;

  function automatic void model_step();
    bit s_stop = stall[3];
    bit n_stop = stall[4];
    if (rst || flush || (s_stop && !n_stop)) begin
      m.valid = 0; m.wd = 0; m.wreg = 0; m.wdata = 0; m.hi = 0; m.lo = 0; m.whilo = 0;
    end else if (!s_stop) begin
      m.valid = ex_valid; m.wd = ex_wd; m.wdata = ex_wdata; m.hi = ex_hi; m.lo = ex_lo;
      m.wreg  = ex_valid && ex_wreg;
      m.whilo = ex_valid && ex_whilo;
    end
    if (rst || flush || !s_stop) begin
      m.ctx = 0; m.ctx_cnt = 0;
    end else begin
      m.ctx = ctx_i; m.ctx_cnt = ctx_cnt_i;
    end
    if (rst || perf_clr) begin
      m.perf16 = 0; m.perf4 = 0;
    end else if (s_stop) begin
      m.perf16 = (m.perf16 < 65535) ? m.perf16 + 1 : 65535;
      m.perf4  = (m.perf4 < 15) ? m.perf4 + 1 : 15;
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; ex_valid = 1; ex_wd = 5'd31; ex_wreg = 1; ex_wdata = 32'hDEADBEEF;
    ex_hi = 32'hFFFF_FFFF; ex_lo = 32'h1; ex_whilo = 1; ctx_i = 64'h77; ctx_cnt_i = 2'd3;
    stall = 6'b001000;
    tick(); tick();
    vectors++;
    if ({mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo} !== '0) begin
      miscompares++;
      $display("FAIL reset_mem got %h %h %h %h %h %h %h exp all zero",
               mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo);
    end
    vectors++;
    if ({ctx_o, ctx_cnt_o} !== '0) begin
      miscompares++; $display("FAIL reset_ctx got %h/%h exp 0/0", ctx_o, ctx_cnt_o);
    end
    vectors++;
    if (stall_cycles !== 16'd0 || stall_cycles4 !== 4'd0) begin
      miscompares++; $display("FAIL reset_perf got %0d/%0d exp 0/0", stall_cycles, stall_cycles4);
    end
    rst = 0; stall = '0;
  endtask

  task automatic test_advance();
    stall = '0; ex_valid = 1; ex_wd = 5'd7; ex_wreg = 1; ex_wdata = 32'h1234_5678;
    ex_whilo = 0; ctx_i = 64'hFACE;
    tick();
    vectors++;
    if (mem_wd !== 5'd7 || mem_wdata !== 32'h1234_5678 || mem_wreg !== 1'b1 || mem_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL advance got wd=%0d wdata=%h wreg=%b valid=%b exp wd=7 wdata=12345678 wreg=1 valid=1",
               mem_wd, mem_wdata, mem_wreg, mem_valid);
    end
    vectors++;
    if (ctx_o !== 64'h0) begin
      miscompares++; $display("FAIL advance_ctx got %h exp 0", ctx_o);
    end
  endtask

  task automatic test_bubble();
    stall = 6'b001000; ctx_i = 64'hA5; ctx_cnt_i = 2'b01; ex_wdata = 32'hCAFE;
    tick();
    vectors++;
    if (mem_wreg !== 1'b0 || mem_wdata !== 32'h0 || mem_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bubble_mem got wreg=%b wdata=%h valid=%b exp 0/0/0", mem_wreg, mem_wdata, mem_valid);
    end
    vectors++;
    if (ctx_o !== 64'hA5 || ctx_cnt_o !== 2'd1) begin
      miscompares++; $display("FAIL bubble_ctx got %h/%0d exp a5/1", ctx_o, ctx_cnt_o);
    end
    stall = '0;
    tick();
    vectors++;
    if (ctx_o !== 64'h0 || ctx_cnt_o !== 2'd0) begin
      miscompares++; $display("FAIL bubble_release_ctx got %h/%0d exp 0/0", ctx_o, ctx_cnt_o);
    end
  endtask

  task automatic test_hold();
    stall = '0; perf_clr = 1; ex_valid = 1; ex_wdata = 32'h55;
    tick();
    perf_clr = 0; stall = 6'b011000;
    for (int i = 0; i < 3; i++) begin
      ex_wdata = 32'h1000 + i;
      tick();
    end
    vectors++;
    if (mem_wdata !== 32'h55) begin
      miscompares++; $display("FAIL hold_wdata got %h exp 55", mem_wdata);
    end
    vectors++;
    if (stall_cycles !== 16'd3) begin
      miscompares++; $display("FAIL hold_perf got %0d exp 3", stall_cycles);
    end
  endtask

  task automatic test_flush();
    stall = 6'b001000; flush = 1; ctx_i = 64'h1122_3344_5566_7788; ctx_cnt_i = 2'd2;
    tick();
    flush = 0;
    vectors++;
    if ({mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo} !== '0) begin
      miscompares++; $display("FAIL flush_mem got valid=%b wdata=%h exp all zero", mem_valid, mem_wdata);
    end
    vectors++;
    if (ctx_o !== 64'h0 || ctx_cnt_o !== 2'd0) begin
      miscompares++; $display("FAIL flush_ctx got %h/%0d exp 0/0", ctx_o, ctx_cnt_o);
    end
    stall = '0;
  endtask

  task automatic test_saturation();
    perf_clr = 1; stall = '0;
    tick();
    perf_clr = 0; stall = 6'b001000;
    for (int i = 0; i < 20; i++) tick();
    vectors++;
    if (stall_cycles4 !== 4'd15) begin
      miscompares++; $display("FAIL sat_perf4 got %0d exp 15", stall_cycles4);
    end
    vectors++;
    if (stall_cycles !== 16'd20) begin
      miscompares++; $display("FAIL sat_perf16 got %0d exp 20", stall_cycles);
    end
    perf_clr = 1;
    tick();
    perf_clr = 0;
    vectors++;
    if (stall_cycles4 !== 4'd0 || stall_cycles !== 16'd0) begin
      miscompares++; $display("FAIL sat_clear got %0d/%0d exp 0/0", stall_cycles4, stall_cycles);
    end
    stall = '0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stall     = 6'($urandom);
      stall[3]  = ($urandom_range(0, 9) < 6);
      stall[4]  = $urandom_range(0, 1);
      flush     = ($urandom_range(0, 9) == 0);
      rst       = ($urandom_range(0, 24) == 0);
      perf_clr  = ($urandom_range(0, 14) == 0);
      ex_valid  = $urandom_range(0, 1);
      ex_wd     = 5'($urandom);
      ex_wreg   = $urandom_range(0, 1);
      ex_wdata  = $urandom;
      ex_hi     = $urandom;
      ex_lo     = $urandom;
      ex_whilo  = $urandom_range(0, 1);
      ctx_i     = {$urandom, $urandom};
      ctx_cnt_i = 2'($urandom);
      tick();
      vectors++;
      if ({mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, ctx_o, ctx_cnt_o} !==
          {m.valid, m.wd, m.wreg, m.wdata, m.hi, m.lo, m.whilo, m.ctx, m.ctx_cnt}) begin
        miscompares++;
        $display("FAIL rand_state[%0d] got v=%b wd=%0d we=%b d=%h hi=%h lo=%h hl=%b ctx=%h/%0d exp v=%b wd=%0d we=%b d=%h hi=%h lo=%h hl=%b ctx=%h/%0d",
                 i, mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, ctx_o, ctx_cnt_o,
                 m.valid, m.wd, m.wreg, m.wdata, m.hi, m.lo, m.whilo, m.ctx, m.ctx_cnt);
      end
      vectors++;
      if (int'(stall_cycles) != m.perf16 || int'(stall_cycles4) != m.perf4) begin
        miscompares++;
        $display("FAIL rand_perf[%0d] got %0d/%0d exp %0d/%0d", i, stall_cycles, stall_cycles4, m.perf16, m.perf4);
      end
    end
    rst = 0; flush = 0; perf_clr = 0; stall = '0;
  endtask

  initial begin
    m = '{default: 0};
    test_reset();
    test_advance();
    test_bubble();
    test_hold();
    test_flush();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
